// File: rtl/clock_monitor_pkg.sv
// Shared types for the clock monitor: FSM state encoding.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/clock_monitor_sync_edge.sv
// Synchroniser for the monitored clock plus a registered rise/fall edge detector.
module clock_monitor_sync_edge #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic mon_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;
    logic                  rise_q;
    logic                  fall_q;
    logic                  sync_s;

    assign sync_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], mon_i};
            prev_q <= sync_s;
            rise_q <= sync_s & ~prev_q;
            fall_q <= ~sync_s & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clock_monitor.sv
// Health monitor for a divided clock: measures half-period, declares lock on a steady
// ratio and raises a sticky error on drift or stall once locked.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXP_HALF    = 2,
    parameter int unsigned TOL         = 0,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             mon_in,
    input  logic             clear_err,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned      STALL_LIM = 4 * EXP_HALF;
    localparam int unsigned      GoodW     = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CtrMax    = '1;
    localparam logic [CNT_W-1:0] StallLimW = CNT_W'(STALL_LIM);
    localparam logic [CNT_W:0]   ExpHalfW  = (CNT_W + 1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TolW      = (CNT_W + 1)'(TOL);
    localparam logic [GoodW-1:0] LockW     = GoodW'(LOCK_COUNT);

    mon_state_e       state_q;
    logic [CNT_W-1:0] ctr_q;
    logic [GoodW-1:0] good_q;
    logic [CNT_W-1:0] half_q;
    logic             valid_q;
    logic             locked_q;
    logic             err_q;

    logic             edge_det;
    logic [CNT_W:0]   ctr_inc;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] half_sat;
    logic [GoodW-1:0] good_inc;
    logic             match;
    logic             stall;

    clock_monitor_sync_edge #(
        .SyncStages(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (clk_in),
        .reset_i(reset),
        .mon_i  (mon_in),
        .rise_o (rise_stb),
        .fall_o (fall_stb)
    );

    // Edge-to-edge distance is ctr+1; one extra bit keeps the compare free of wrap.
    assign edge_det = rise_stb | fall_stb;
    assign ctr_inc  = {1'b0, ctr_q} + 1'b1;
    assign diff     = (ctr_inc >= ExpHalfW) ? (ctr_inc - ExpHalfW) : (ExpHalfW - ctr_inc);
    assign match    = (diff <= TolW);
    assign half_sat = ctr_inc[CNT_W] ? CtrMax : ctr_inc[CNT_W-1:0];
    assign stall    = (ctr_q == StallLimW);
    assign good_inc = good_q + 1'b1;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= StIdle;
            ctr_q    <= '0;
            good_q   <= '0;
            half_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (edge_det) begin
                ctr_q <= '0;
            end else if (ctr_q != CtrMax) begin
                ctr_q <= ctr_q + 1'b1;
            end

            if (edge_det && (state_q != StIdle)) begin
                half_q  <= half_sat;
                valid_q <= 1'b1;
            end

            // A same-cycle error set below overrides this clear.
            if (clear_err) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (edge_det) begin
                        state_q <= StMeasure;
                        good_q  <= '0;
                    end
                end
                StMeasure: begin
                    if (edge_det && match) begin
                        good_q <= good_inc;
                        if (good_inc == LockW) begin
                            state_q  <= StLocked;
                            locked_q <= 1'b1;
                        end
                    end else if (edge_det || stall) begin
                        good_q <= '0;
                    end
                end
                StLocked: begin
                    if ((edge_det && !match) || stall) begin
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                        state_q  <= StMeasure;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign half_period  = half_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign err          = err_q;

endmodule
